frv_imem_prefetch: RTL and testbench
====================================

// Module: frv_imem_prefetch
// PURPOSE
//  Instruction prefetch buffer between the FazyRV core's wb_imem master port and the
//  instruction memory Wishbone bus. Fetches sequential words ahead into a small FIFO.
//  Sequential core fetches are served with 1-cycle latency; non-sequential fetches flush it.
//  Classic Wishbone on both sides, one word per transfer, no bursts.
// PARAMETERS
//  DEPTH  4  buffer entries, power of two, >=2; max words fetched ahead of the core
// PORTS
//  clk_i     in   1   clock, all logic on rising edge
//  rst_in    in   1   reset, synchronous, active-low
//  s_cyc_i   in   1   core-side Wishbone cycle
//  s_stb_i   in   1   core-side strobe; core holds it (and s_adr_i) until s_ack_o
//  s_adr_i   in   32  core fetch byte address; [1:0] ignored
//  s_dat_o   out  32  instruction word, valid while s_ack_o=1
//  s_ack_o   out  1   one-cycle acknowledge to core
//  m_cyc_o   out  1   memory-side cycle; always equal to m_stb_o
//  m_stb_o   out  1   memory-side strobe, registered
//  m_adr_o   out  32  memory word address, [1:0]=0
//  m_dat_i   in   32  memory read data, sampled when m_ack_i=1
//  m_ack_i   in   1   memory acknowledge
// BEHAVIOUR
//  Reset (rst_in=0 at edge): s_ack_o=0, s_dat_o=0, m_cyc_o=m_stb_o=0, m_adr_o=0.
//   Also buffer emptied, primed=0, FSM=IDLE. Reset mid-transfer drops m_cyc_o on that edge.
//  State: FIFO of DEPTH words, count, head_adr (addr of next word owed to core), pf_adr
//   (next addr to fetch), primed flag. All addresses wrap mod 2^32 (+4 from 0xFFFFFFFC -> 0).
//  Core request pending: s_cyc_i & s_stb_i & ~s_ack_o. No request accepted in a s_ack_o cycle.
//   Max rate is 1 ack per 2 cycles.
//  Hit: pending & primed & count>0 & s_adr_i[31:2]==head_adr[31:2].
//   Next cycle s_ack_o=1, s_dat_o=head word. Pop; head_adr+=4.
//  Wait: pending & primed & count==0 & addr==head_adr -> no action; word is in flight.
//  Miss: pending & (~primed | addr!=head_adr). Flush all entries: count=0, head_adr=pf_adr=addr,
//   primed=1. No ack this cycle; the request stays pending and becomes a hit once filled.
//  Memory FSM:
//   IDLE  : primed & count+outstanding<DEPTH -> FETCH, m_stb_o=1, m_adr_o=pf_adr (next edge).
//   FETCH : hold m_stb_o/m_adr_o until m_ack_i. On ack: push m_dat_i, pf_adr+=4.
//           Then FETCH again at new pf_adr if room remains (no idle cycle), else IDLE.
//   DRAIN : entered on a miss while FETCH unacked. Hold the strobe; on m_ack_i discard data.
//           Then go to FETCH at pf_adr (new target).
//  Miss in same cycle as m_ack_i in FETCH: data discarded, next FETCH is at the new address.
//  Miss in DRAIN: update pf_adr only; stay in DRAIN.
//  Push and pop in same cycle: count unchanged. Full (count==DEPTH): no new fetch issued.
//  Core drops s_cyc_i/s_stb_i before ack: request abandoned, no ack, buffer/prefetch unaffected.
//  Latency, zero-wait memory (m_ack_i in first strobe cycle):
//   hit = ack at t+1; cold miss at t = m_stb t+1, s_ack_o at t+3.
// TESTING
//  1 Hold rst_in=0 3 cycles, then idle -> all outputs 0; m_stb_o stays 0 with no core request.
//  2 Zero-wait mem, request 0x40 at t -> m_adr 0x40@t+1, s_ack_o@t+3, s_dat=mem[0x40].
//    Prefetch continues 0x44,0x48,0x4C,0x50, then m_stb_o=0 while the buffer stays full.
//  3 Sequential stream 0x40..0x7C after warmup -> each ack 1 cycle after request, data in order.
//    m_adr strictly +4; never more than DEPTH words ahead of the core.
//  4 3-wait mem, FETCH of 0x48 in flight, core requests 0x100 -> 0x48 acked by mem, discarded.
//    Next m_adr=0x100; core gets mem[0x100]; 0x48 data never reaches s_dat_o.
//  5 Request 0xFFFFFFF8 -> prefetch 0xFFFFFFFC then 0x00000000; both served correctly in sequence.
//  6 Core drops s_stb_i mid-miss for 0x200, later re-requests 0x200 -> no ack to the dropped request.
//    The re-request hits with no second memory fetch. Also rst_in=0 during FETCH -> m_stb_o=0 next cycle.

Source files
------------

// File: rtl/frv_imem_prefetch.sv
// frv_imem_prefetch: sequential instruction prefetch FIFO between the core's
// Wishbone instruction port and the instruction memory bus.
module frv_imem_prefetch #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic [31:0] s_adr_i,
  output logic [31:0] s_dat_o,
  output logic        s_ack_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic [31:0] m_adr_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [29:0]   ADR_ONE  = 30'd1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t      state;
  logic [31:0] buf_q [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0] count;
  logic [AW:0] count_nxt;
  logic [29:0] head_adr;
  logic [29:0] pf_adr;
  logic [29:0] fetch_adr;
  logic        primed;
  logic        pending;
  logic        adr_match;
  logic        hit;
  logic        miss;
  logic        push;

  assign m_adr_o = {fetch_adr, 2'b00};
  assign m_cyc_o = m_stb_o;

  // Classify the core request and work out the buffer occupancy after this edge
  always_comb begin
    pending   = s_cyc_i & s_stb_i & ~s_ack_o;
    adr_match = (s_adr_i[31:2] == head_adr);
    miss      = pending & (~primed | ~adr_match);
    hit       = pending & primed & (count != '0) & adr_match;
    // A miss flushes, so a word landing on the same edge is thrown away
    push      = (state == FETCH) & m_ack_i & ~miss;
    count_nxt = count;
    if (miss) begin
      count_nxt = '0;
    end else begin
      unique case ({push, hit})
        2'b10:   count_nxt = count + CNT_ONE;
        2'b01:   count_nxt = count - CNT_ONE;
        default: count_nxt = count;
      endcase
    end
  end

  // Buffer storage, written when a fetched word is kept
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_q[wr_ptr] <= m_dat_i;
    end
  end

  // Core side: acknowledge hits, track the head of the buffer, flush on a miss
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      s_ack_o  <= 1'b0;
      s_dat_o  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      head_adr <= '0;
      primed   <= 1'b0;
    end else begin
      s_ack_o <= hit;
      count   <= count_nxt;
      if (hit) begin
        s_dat_o <= buf_q[rd_ptr];
      end
      if (miss) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        head_adr <= s_adr_i[31:2];
        primed   <= 1'b1;
      end else begin
        if (hit) begin
          rd_ptr   <= rd_ptr + PTR_ONE;
          head_adr <= head_adr + ADR_ONE;
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
      end
    end
  end

  // Memory-side FSM; while a strobe is up fetch_adr equals pf_adr except in DRAIN,
  // where fetch_adr is the abandoned word and pf_adr the new target
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state     <= IDLE;
      m_stb_o   <= 1'b0;
      fetch_adr <= '0;
      pf_adr    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss) begin
            state     <= FETCH;
            m_stb_o   <= 1'b1;
            fetch_adr <= s_adr_i[31:2];
            pf_adr    <= s_adr_i[31:2];
          end else if (primed && (count < CNT_FULL)) begin
            state     <= FETCH;
            m_stb_o   <= 1'b1;
            fetch_adr <= pf_adr;
          end
        end
        FETCH: begin
          if (miss) begin
            pf_adr <= s_adr_i[31:2];
            if (m_ack_i) begin
              fetch_adr <= s_adr_i[31:2];
            end else begin
              state <= DRAIN;
            end
          end else if (m_ack_i) begin
            pf_adr <= pf_adr + ADR_ONE;
            if (count_nxt < CNT_FULL) begin
              fetch_adr <= pf_adr + ADR_ONE;
            end else begin
              state   <= IDLE;
              m_stb_o <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (miss) begin
            pf_adr <= s_adr_i[31:2];
          end
          if (m_ack_i) begin
            state     <= FETCH;
            fetch_adr <= miss ? s_adr_i[31:2] : pf_adr;
          end
        end
        default: begin
          state   <= IDLE;
          m_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frv_imem_prefetch.sv
// Self-checking bench for frv_imem_prefetch: memory model with programmable
// wait states, transaction-level checking of every core acknowledge.
module tb_frv_imem_prefetch;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_in;
  logic        s_cyc_i;
  logic        s_stb_i;
  logic [31:0] s_adr_i;
  logic [31:0] s_dat_o;
  logic        s_ack_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;

  int unsigned cyc;
  int          n_cmp;
  int          n_err;
  int          wait_states;
  int          wait_cnt;
  int          ack_cnt;
  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_adr;
  logic [31:0] last_acked;
  logic        ahead_chk;
  logic        have_last;
  logic [31:0] last_fetch;
  logic [31:0] log_adr[$];
  int unsigned log_cyc[$];

  frv_imem_prefetch #(.DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_in (rst_in),
    .s_cyc_i(s_cyc_i),
    .s_stb_i(s_stb_i),
    .s_adr_i(s_adr_i),
    .s_dat_o(s_dat_o),
    .s_ack_o(s_ack_o),
    .m_cyc_o(m_cyc_o),
    .m_stb_o(m_stb_o),
    .m_adr_o(m_adr_o),
    .m_dat_i(m_dat_i),
    .m_ack_i(m_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents as a function of word address
  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w ^ 32'hDEAD_BEEF) + {w[7:0], w[31:8]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process and memory model, both evaluated mid-cycle
  always @(negedge clk) begin
    check("cyc_eq_stb", {31'd0, m_cyc_o}, {31'd0, m_stb_o});
    if (m_stb_o) check("m_adr_align", {30'd0, m_adr_o[1:0]}, 32'd0);
    if (s_ack_o) begin
      ack_cnt++;
      check("ack_has_req", {31'd0, prev_req}, 32'd1);
      check("ack_not_back2back", {31'd0, prev_ack}, 32'd0);
      check("s_dat", s_dat_o, memf(prev_adr));
      last_acked = {prev_adr[31:2], 2'b00};
    end
    m_ack_i = 1'b0;
    if (m_stb_o) begin
      if (wait_cnt >= wait_states) begin
        m_ack_i  = 1'b1;
        m_dat_i  = memf(m_adr_o);
        wait_cnt = 0;
        log_adr.push_back(m_adr_o);
        log_cyc.push_back(cyc);
        if (ahead_chk) begin
          check("fetch_ahead_bound", {31'd0, ((m_adr_o - last_acked) <= 4 * DEPTH)}, 32'd1);
          if (have_last) check("fetch_seq", m_adr_o, last_fetch + 32'd4);
          have_last  = 1'b1;
          last_fetch = m_adr_o;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    prev_req = s_cyc_i & s_stb_i & ~s_ack_o;
    prev_adr = s_adr_i;
    prev_ack = s_ack_o;
  end

  // Present one request; hold it until ack or max_cyc cycles elapse
  task automatic do_req(input logic [31:0] a, input int max_cyc, input logic must_ack,
                        output logic [31:0] d, output int lat);
    int unsigned t0;
    @(posedge clk); #1;
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    s_adr_i = a;
    t0  = cyc;
    lat = -1;
    d   = '0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (s_ack_o) begin
        lat = int'(cyc - t0);
        d   = s_dat_o;
        break;
      end
    end
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    if (must_ack && lat < 0) check("req_timeout", 32'hFFFF_FFFF, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  function automatic int count_log(input logic [31:0] a);
    int c;
    c = 0;
    foreach (log_adr[i]) if (log_adr[i] == a) c++;
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    int          lat;
    int unsigned t;
    int          acks0;
    logic        seen;

    n_cmp = 0; n_err = 0; cyc = 0; wait_states = 0; wait_cnt = 0; ack_cnt = 0;
    prev_req = 0; prev_ack = 0; prev_adr = 0; last_acked = 0;
    ahead_chk = 0; have_last = 0; last_fetch = 0;
    m_ack_i = 0; m_dat_i = 0;
    s_cyc_i = 0; s_stb_i = 0; s_adr_i = 0;
    rst_in = 1'b0;

    // 1: reset state and quiet bus
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ack", {31'd0, s_ack_o}, 32'd0);
    check("rst_s_dat", s_dat_o, 32'd0);
    check("rst_m_stb", {31'd0, m_stb_o}, 32'd0);
    check("rst_m_cyc", {31'd0, m_cyc_o}, 32'd0);
    check("rst_m_adr", m_adr_o, 32'd0);
    rst_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | m_stb_o;
    end
    check("idle_no_stb", {31'd0, seen}, 32'd0);

    // 2: cold miss with zero-wait memory, then fill to DEPTH ahead
    log_adr.delete(); log_cyc.delete();
    @(posedge clk); #1;
    t = cyc;
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_adr_i = 32'h40;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (s_ack_o) begin
        lat = int'(cyc - t);
        d   = s_dat_o;
        break;
      end
    end
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    check("cold_lat", 32'(lat), 32'd3);
    check("cold_dat", d, memf(32'h40));
    check("cold_first_adr", log_adr.size() > 0 ? log_adr[0] : 32'hX, 32'h40);
    check("cold_first_cyc", log_cyc.size() > 0 ? log_cyc[0] : 32'hX, t + 1);
    idle(12);
    check("fill_count", log_adr.size(), 32'd5);
    for (int i = 1; i < 5; i++)
      if (log_adr.size() > i) check("fill_adr", log_adr[i], 32'h40 + 32'(4 * i));
    check("full_no_stb", {31'd0, m_stb_o}, 32'd0);

    // 3: sequential stream, every request a 1-cycle hit
    ahead_chk = 1'b1; have_last = 1'b1; last_fetch = 32'h50;
    for (int i = 1; i < 16; i++) begin
      do_req(32'h40 + 32'(4 * i), 10, 1'b1, d, lat);
      check("stream_lat", 32'(lat), 32'd1);
      check("stream_dat", d, memf(32'h40 + 32'(4 * i)));
    end
    idle(8);
    ahead_chk = 1'b0; have_last = 1'b0;

    // 4: miss during an in-flight fetch with 3-wait memory
    wait_states = 3;
    do_req(32'h40, 40, 1'b1, d, lat);
    do_req(32'h44, 40, 1'b1, d, lat);
    log_adr.delete(); log_cyc.delete();
    do_req(32'h100, 40, 1'b1, d, lat);
    check("drain_dat", d, memf(32'h100));
    check("drain_discard_adr", log_adr.size() > 0 ? log_adr[0] : 32'hX, 32'h48);
    check("drain_next_adr", log_adr.size() > 1 ? log_adr[1] : 32'hX, 32'h100);
    idle(30);

    // 5: address wrap at the top of the space
    wait_states = 0;
    log_adr.delete(); log_cyc.delete();
    do_req(32'hFFFF_FFF8, 20, 1'b1, d, lat);
    check("wrap_dat0", d, memf(32'hFFFF_FFF8));
    do_req(32'hFFFF_FFFC, 20, 1'b1, d, lat);
    check("wrap_lat1", 32'(lat), 32'd1);
    check("wrap_dat1", d, memf(32'hFFFF_FFFC));
    do_req(32'h0000_0000, 20, 1'b1, d, lat);
    check("wrap_lat2", 32'(lat), 32'd1);
    check("wrap_dat2", d, memf(32'h0));
    check("wrap_log1", log_adr.size() > 1 ? log_adr[1] : 32'hX, 32'hFFFF_FFFC);
    check("wrap_log2", log_adr.size() > 2 ? log_adr[2] : 32'hX, 32'h0);
    idle(10);

    // 6: abandoned miss, later re-request hits without refetch
    wait_states = 3;
    log_adr.delete(); log_cyc.delete();
    acks0 = ack_cnt;
    do_req(32'h200, 1, 1'b0, d, lat);
    idle(40);
    check("abandon_no_ack", 32'(ack_cnt - acks0), 32'd0);
    check("abandon_fetched_once", 32'(count_log(32'h200)), 32'd1);
    do_req(32'h200, 20, 1'b1, d, lat);
    check("rereq_lat", 32'(lat), 32'd1);
    check("rereq_dat", d, memf(32'h200));
    idle(10);
    check("rereq_no_refetch", 32'(count_log(32'h200)), 32'd1);

    // 6b: reset while a fetch is outstanding
    @(posedge clk); #1;
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_adr_i = 32'h300;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      seen = m_stb_o;
    end
    check("rst_fetch_started", {31'd0, seen}, 32'd1);
    rst_in = 1'b0; s_cyc_i = 1'b0; s_stb_i = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_stb", {31'd0, m_stb_o}, 32'd0);
    check("rst_mid_adr", m_adr_o, 32'd0);
    rst_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | m_stb_o;
    end
    check("rst_mid_quiet", {31'd0, seen}, 32'd0);

    // Randomized traffic: mostly sequential, random jumps, random drops
    a = 32'h0000_1000;
    for (int i = 0; i < 200; i++) begin
      wait_states = $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 7) a = {a[31:2] + 30'd1, 2'($urandom_range(0, 3))};
      else a = ($urandom() & 32'h0000_0FFC) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) do_req(a, $urandom_range(1, 3), 1'b0, d, lat);
      else begin
        do_req(a, 60, 1'b1, d, lat);
        check("rand_dat", d, memf(a));
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
